// File: rtl/csr_file.sv
// Machine-mode CSR register file: CSRRW/S/C(I) execution, trap entry, mret,
// and the free-running mcycle/minstret counters.
module csr_file #(
    parameter int          XLEN    = 64,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csrrx,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] src_val;
    logic [XLEN-1:0] csr_wdata;
    logic            implemented;
    logic            write_req;
    logic            illegal_op;
    logic            csr_we;
    logic            sys_event;

    // Low pc bits are always discarded when latching mepc on a trap.
    logic unused_trap_pc_lsbs;
    assign unused_trap_pc_lsbs = ^trap_pc[1:0];

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;
    end

    always_comb begin
        implemented = 1'b1;
        old_val     = '0;
        case (csr_addr)
            ADDR_MSTATUS:  old_val = mstatus_val;
            ADDR_MTVEC:    old_val = mtvec_q;
            ADDR_MSCRATCH: old_val = mscratch_q;
            ADDR_MEPC:     old_val = mepc_q;
            ADDR_MCAUSE:   old_val = mcause_q;
            ADDR_MCYCLE:   old_val = mcycle_q;
            ADDR_MINSTRET: old_val = minstret_q;
            ADDR_MHARTID:  old_val = XLEN'(HART_ID);
            default:       implemented = 1'b0;
        endcase
    end

    // Set/clear with a zero operand index is a pure read and never faults on read-only CSRs.
    always_comb begin
        src_val    = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;
        write_req  = (funct3[1:0] == 2'b01) || (zimm != 5'd0);
        illegal_op = csrrx && ((funct3[1:0] == 2'b00) || !implemented ||
                               (write_req && (csr_addr[11:10] == 2'b11)));
        csr_we     = csrrx && !illegal_op && write_req && !reset;
        sys_event  = trap_valid || mret;
        csr_wdata  = src_val;
        case (funct3[1:0])
            2'b10:   csr_wdata = old_val | src_val;
            2'b11:   csr_wdata = old_val & ~src_val;
            default: csr_wdata = src_val;
        endcase
    end

    always_comb begin
        csr_rdata      = (!reset && csrrx && !illegal_op) ? old_val : '0;
        illegal        = illegal_op && !reset;
        redirect_valid = sys_event && !reset;
        redirect_pc    = '0;
        if (trap_valid) begin
            redirect_pc = mtvec_q;
        end else if (mret) begin
            redirect_pc = mepc_q;
        end
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = instr_retire ? minstret_q + XLEN'(1) : minstret_q;

        // Trap/mret own mstatus, mepc and mcause in their cycle; CSR writes there are dropped.
        if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: if (!sys_event) begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                ADDR_MTVEC:    mtvec_d    = {csr_wdata[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_d = csr_wdata;
                ADDR_MEPC:     if (!sys_event) mepc_d = {csr_wdata[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   if (!sys_event) mcause_d = csr_wdata;
                ADDR_MCYCLE:   mcycle_d   = csr_wdata;
                ADDR_MINSTRET: minstret_d = csr_wdata;
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a register-map model checked every cycle,
// plus hand-computed literal expectations on selected cycles.
module tb_csr_file;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        csrrx = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [11:0] csr_addr = '0;
    logic [63:0] rs1_data = '0;
    logic [4:0]  zimm = '0;
    logic        instr_retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_pc = '0;
    logic        mret = 1'b0;
    logic [63:0] csr_rdata;
    logic        illegal;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    csr_file #(.XLEN(64), .HART_ID(0)) dut (
        .clk(clk), .reset(reset), .csrrx(csrrx), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
        .instr_retire(instr_retire), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
        .csr_rdata(csr_rdata), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int total = 0;
    int bad = 0;

    // Literal expectation for the current cycle: sel 0 = csr_rdata, 1 = redirect_pc, 2 = illegal
    logic        lit_en = 1'b0;
    int          lit_sel = 0;
    logic [63:0] lit_val = '0;
    string       lit_name = "";

    logic [63:0] regs [int];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        regs.delete();
        regs[32'h300] = 64'h1800;
        regs[32'h305] = 64'h0;
        regs[32'h340] = 64'h0;
        regs[32'h341] = 64'h0;
        regs[32'h342] = 64'h0;
        regs[32'hB00] = 64'h0;
        regs[32'hB02] = 64'h0;
        regs[32'hF14] = 64'h0;
    endtask

    // Compare process: outputs against the register-map model, then advance the model.
    initial begin
        logic [63:0] e_rd, e_pc, old_v, src, nv, st, act;
        logic        e_ill, e_rv, impl, wants;
        logic [63:0] nregs [int];
        int          a;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                e_rd = '0; e_ill = 1'b0; e_rv = 1'b0; e_pc = '0;
                check("rdata", csr_rdata, e_rd);
                check("illegal", {63'b0, illegal}, {63'b0, e_ill});
                check("redirect_valid", {63'b0, redirect_valid}, {63'b0, e_rv});
                model_reset();
            end else begin
                a     = int'(csr_addr);
                impl  = regs.exists(a);
                old_v = impl ? regs[a] : 64'h0;
                src   = funct3[2] ? {59'b0, zimm} : rs1_data;
                wants = (funct3[1:0] == 2'b01) || (zimm != 5'd0);
                e_ill = csrrx && ((funct3[1:0] == 2'b00) || !impl ||
                                  (wants && csr_addr[11:10] == 2'b11));
                e_rd  = (csrrx && !e_ill) ? old_v : 64'h0;
                e_rv  = trap_valid || mret;
                e_pc  = trap_valid ? regs[32'h305] : regs[32'h341];
                check("rdata", csr_rdata, e_rd);
                check("illegal", {63'b0, illegal}, {63'b0, e_ill});
                check("redirect_valid", {63'b0, redirect_valid}, {63'b0, e_rv});
                if (e_rv) check("redirect_pc", redirect_pc, e_pc);

                nregs = regs;
                nregs[32'hB00] = regs[32'hB00] + 64'd1;
                if (instr_retire) nregs[32'hB02] = regs[32'hB02] + 64'd1;
                if (csrrx && !e_ill && wants) begin
                    nv = (funct3[1:0] == 2'b01) ? src :
                         (funct3[1:0] == 2'b10) ? (old_v | src) : (old_v & ~src);
                    if ((a == 32'h300 || a == 32'h341 || a == 32'h342) && (trap_valid || mret)) begin
                        nv = nv;
                    end else if (a == 32'h300) begin
                        nregs[a] = (nv & 64'h88) | 64'h1800;
                    end else if (a == 32'h305 || a == 32'h341) begin
                        nregs[a] = nv & ~64'h3;
                    end else begin
                        nregs[a] = nv;
                    end
                end
                st = regs[32'h300];
                if (trap_valid) begin
                    nregs[32'h341] = trap_pc & ~64'h3;
                    nregs[32'h342] = trap_cause;
                    nregs[32'h300] = 64'h1800 | (st[3] ? 64'h80 : 64'h0);
                end else if (mret) begin
                    nregs[32'h300] = 64'h1880 | (st[7] ? 64'h8 : 64'h0);
                end
                regs = nregs;
            end
            if (lit_en) begin
                act = (lit_sel == 0) ? csr_rdata :
                      (lit_sel == 1) ? redirect_pc : {63'b0, illegal};
                check(lit_name, act, lit_val);
            end
        end
    end

    task automatic cyc(input logic cx, input logic [2:0] f3, input logic [11:0] ad,
                       input logic [63:0] r, input logic [4:0] z);
        @(negedge clk);
        reset = 1'b0; csrrx = cx; funct3 = f3; csr_addr = ad; rs1_data = r; zimm = z;
        instr_retire = 1'b0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 3'b000, 12'h000, 64'h0, 5'd0);
    endtask

    task automatic rd(input logic [11:0] ad);
        cyc(1'b1, 3'b010, ad, 64'h0, 5'd0);
    endtask

    task automatic lit(input string nm, input int sel, input logic [63:0] v);
        lit_en = 1'b1; lit_sel = sel; lit_val = v; lit_name = nm;
    endtask

    initial begin
        // Reset, including a would-be illegal op that must stay silent
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'b000, 12'h7C0, 64'h0, 5'd0); reset = 1'b1;
            lit("reset_illegal", 2, 64'h0);
        end
        for (int i = 0; i < 5; i++) idle();
        cyc(1'b1, 3'b010, 12'hB00, 64'h55, 5'd0); lit("mcycle_after_5", 0, 64'd5);
        rd(12'h300);                              lit("mstatus_reset", 0, 64'h1800);

        cyc(1'b1, 3'b001, 12'h340, 64'hDEAD_BEEF, 5'd1); lit("mscratch_rw_old", 0, 64'h0);
        rd(12'h340);                              lit("mscratch_new", 0, 64'hDEAD_BEEF);

        cyc(1'b1, 3'b110, 12'h300, 64'h0, 5'd8);  lit("rsi_mstatus", 0, 64'h1800);
        cyc(1'b1, 3'b111, 12'h300, 64'h0, 5'd8);  lit("rci_mstatus", 0, 64'h1808);
        rd(12'h300);                              lit("mstatus_final", 0, 64'h1800);

        cyc(1'b1, 3'b001, 12'h305, 64'h8000_0103, 5'd2);
        idle(); trap_valid = 1'b1; trap_cause = 64'd2; trap_pc = 64'h8000_0042;
        lit("trap_target", 1, 64'h8000_0100);
        rd(12'h341);                              lit("mepc_trap", 0, 64'h8000_0040);
        rd(12'h342);                              lit("mcause_trap", 0, 64'd2);
        rd(12'h300);                              lit("mstatus_trap", 0, 64'h1800);

        // Enable MIE, trap alongside a mscratch write, then mret
        cyc(1'b1, 3'b110, 12'h300, 64'h0, 5'd8);
        cyc(1'b1, 3'b001, 12'h340, 64'h1234, 5'd4);
        trap_valid = 1'b1; trap_cause = 64'd11; trap_pc = 64'h8000_0204;
        rd(12'h300);                              lit("mstatus_mpie", 0, 64'h1880);
        rd(12'h340);                              lit("mscratch_with_trap", 0, 64'h1234);
        idle(); mret = 1'b1;                      lit("mret_target", 1, 64'h8000_0204);
        rd(12'h300);                              lit("mstatus_mret", 0, 64'h1888);

        cyc(1'b1, 3'b001, 12'hF14, 64'h5, 5'd3);  lit("mhartid_rw", 2, 64'h1);
        rd(12'hF14);                              lit("mhartid_rs0", 2, 64'h0);
        rd(12'h7C0);                              lit("unimpl_addr", 2, 64'h1);
        cyc(1'b1, 3'b000, 12'h300, 64'h0, 5'd1);  lit("funct3_000", 2, 64'h1);
        cyc(1'b1, 3'b100, 12'h300, 64'h0, 5'd1);  lit("funct3_100", 2, 64'h1);

        cyc(1'b1, 3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
        idle();
        rd(12'hB00);                              lit("mcycle_wrap", 0, 64'h0);

        for (int i = 0; i < 3; i++) begin idle(); instr_retire = 1'b1; end
        rd(12'hB02);                              lit("minstret_3", 0, 64'd3);
        cyc(1'b1, 3'b001, 12'hB02, 64'd100, 5'd7); instr_retire = 1'b1;
        rd(12'hB02);                              lit("minstret_wr", 0, 64'd100);

        // Trap and mret together, with a dropped mepc write
        cyc(1'b1, 3'b001, 12'h341, 64'hFFF, 5'd1);
        trap_valid = 1'b1; mret = 1'b1; trap_cause = 64'd7; trap_pc = 64'h300;
        lit("trap_over_mret", 1, 64'h8000_0100);
        rd(12'h300);                              lit("mstatus_trap2", 0, 64'h1880);
        rd(12'h341);                              lit("mepc_drop_write", 0, 64'h300);
        cyc(1'b1, 3'b001, 12'h341, 64'h1003, 5'd1);
        rd(12'h341);                              lit("mepc_align", 0, 64'h1000);

        cyc(1'b1, 3'b010, 12'h340, 64'hF0, 5'd5); lit("rs_mscratch", 0, 64'h1234);
        cyc(1'b1, 3'b011, 12'h340, 64'h30, 5'd5); lit("rc_mscratch", 0, 64'h12F4);
        cyc(1'b1, 3'b011, 12'h340, 64'hFFFF, 5'd0);
        rd(12'h340);                              lit("rc_x0_nowrite", 0, 64'h12C4);

        // Reset in the middle of activity overrides everything
        cyc(1'b1, 3'b001, 12'h340, 64'hAAAA, 5'd1); reset = 1'b1; trap_valid = 1'b1;
        lit("reset_mid_rdata", 0, 64'h0);
        rd(12'hB00);                              lit("mcycle_post_reset", 0, 64'h0);
        rd(12'h340);                              lit("mscratch_post_reset", 0, 64'h0);
        rd(12'h300);                              lit("mstatus_post_reset", 0, 64'h1800);
        idle();

        @(negedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
